vga_timing_gen: RTL

- Generates raster scan timing for a 640x480 @ 60 Hz VGA display.
- Outputs DrawX/DrawY to color_mapper and takes back its combinational Red/Green/Blue.
- Registers pixel data together with HS/VS/BLANK so that all VGA pins are aligned.
- Provides a once-per-frame pulse (frame_clk) that game logic uses to update player, bullet and health state during vertical blanking.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/pixel_clk_div.sv | 35 +++
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants and vertical-phase encoding shared by the VGA raster
// generator and anything that needs to reason about the 640x480@60 frame.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned CLK_DIV   = 2;

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;

    typedef enum logic [1:0] {VACT, VFP, VSYNC, VBP} vstate_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Connection bundle between the raster generator, the colour mapper that feeds
// it, and the VGA DAC pins it drives.
interface vga_timing_gen_if;

    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pix_en;
    logic       frame_clk;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        input  Red, Green, Blue,
        output DrawX, DrawY, pix_en, frame_clk, VGA_CLK, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output Red, Green, Blue,
        input  DrawX, DrawY, pix_en, frame_clk, VGA_CLK, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
    );

endinterface

// File: rtl/pixel_clk_div.sv
// Divides the system clock down to the pixel rate: a one-cycle pixel strobe on
// the last count and a registered, roughly square pixel clock for the DAC.
module pixel_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Reset,
    output logic pix_en,
    output logic pix_clk
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_nxt;

    assign pix_en  = (div_cnt == LAST);
    assign div_nxt = pix_en ? '0 : div_cnt + CW'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
            pix_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            // Built from the next count so the clock edge lines up with div_cnt.
            pix_clk <= (div_nxt >= HALF);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate scan counters, a vertical-phase FSM and an
// output stage that registers colour, sync and blank on the same pixel strobe.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS = H_VISIBLE,
    parameter int unsigned H_FP  = H_FRONT,
    parameter int unsigned H_SW  = H_SYNC,
    parameter int unsigned H_BP  = H_BACK,
    parameter int unsigned V_VIS = V_VISIBLE,
    parameter int unsigned V_FP  = V_FRONT,
    parameter int unsigned V_SW  = V_SYNC,
    parameter int unsigned V_BP  = V_BACK,
    parameter int unsigned DIV   = CLK_DIV
) (
    input  logic             Clk,
    input  logic             Reset,
    vga_timing_gen_if.master vga
);

    localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SW - 1);
    localparam logic [9:0] VACT_LAST  = 10'(V_VIS - 1);
    localparam logic [9:0] VFP_LAST   = 10'(V_VIS + V_FP - 1);
    localparam logic [9:0] VSYNC_LAST = 10'(V_VIS + V_FP + V_SW - 1);

    logic       pix_en;
    logic       pix_clk;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       line_end;
    vstate_t    vstate;
    vstate_t    vstate_nxt;
    logic       frame_start;
    logic       vis;
    logic       in_hsync;
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;
    logic       blank_n_q;
    logic       hs_q;
    logic       vs_q;
    logic       frame_q;

    pixel_clk_div #(.CLK_DIV(DIV)) u_div (
        .Clk    (Clk),
        .Reset  (Reset),
        .pix_en (pix_en),
        .pix_clk(pix_clk)
    );

    assign line_end = pix_en && (hc == H_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) vstate <= VACT;
        else       vstate <= vstate_nxt;
    end

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        vstate_nxt  = vstate;
        frame_start = 1'b0;
        // The phase only moves at the end of a line, so it tracks vc exactly.
        if (line_end) begin
            case (vstate)
                VACT:    if (vc == VACT_LAST) begin
                             vstate_nxt  = VFP;
                             frame_start = 1'b1;
                         end
                VFP:     if (vc == VFP_LAST)   vstate_nxt = VSYNC;
                VSYNC:   if (vc == VSYNC_LAST) vstate_nxt = VBP;
                VBP:     if (vc == V_LAST)     vstate_nxt = VACT;
                default:                       vstate_nxt = VACT;
            endcase
        end
    end

    assign vis      = (hc < H_VIS_END) && (vstate == VACT);
    assign in_hsync = (hc >= HS_FIRST) && (hc <= HS_LAST);

    // Colour, blank and both syncs are captured together so they share latency.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            blank_n_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= frame_start;
            if (pix_en) begin
                r_q       <= vis ? vga.Red   : 8'h00;
                g_q       <= vis ? vga.Green : 8'h00;
                b_q       <= vis ? vga.Blue  : 8'h00;
                blank_n_q <= vis;
                hs_q      <= !in_hsync;
                vs_q      <= (vstate != VSYNC);
            end
        end
    end

    assign vga.DrawX       = hc;
    assign vga.DrawY       = vc;
    assign vga.pix_en      = pix_en;
    assign vga.frame_clk   = frame_q;
    assign vga.VGA_CLK     = pix_clk;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_R       = r_q;
    assign vga.VGA_G       = g_q;
    assign vga.VGA_B       = b_q;

endmodule
